serial_alu_ctrl: RTL
====================

# serial_alu_ctrl

Bit-serial ALU controller that sequences a single 1-bit ALU slice over WIDTH clock cycles to execute a full-width ADD, SUB, XOR, SLT, AND or OR. It decodes a command into per-bit slice controls (operation select, invertA, invertB, initial carry), shifts operands LSB-first through the slice and assembles the result word and flags. It sits between an instruction sequencer and the slice datapath, trading latency for area.

## Interface
- WIDTH, 32, operand/result width; ≥2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- command  input  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 OR, 6/7 reserved.
- operandA  input  WIDTH  first operand, sampled on acceptance.
- operandB  input  WIDTH  second operand, sampled on acceptance.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  registered result; held until next completion.
- carryout  output  1  MSB carry-out (ADD/SUB), else 0.
- overflow  output  1  signed overflow (ADD/SUB), else 0.
- zero  output  1  result==0.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: ready=1, done=0, result=0, carryout=0, overflow=0, zero=1; bit counter 0, carry flop 0.
- IDLE: start=1 → latch operandA/B/command into shift registers, load carry flop (1 for SUB/SLT, else 0), counter=0, go RUN. start=0 → stay.
- RUN: each cycle slice processes bit[counter]; A/B shift right; result shift register shifts in slice bit at MSB; carry flop ← slice carry; counter increments. After bit WIDTH-1 → DONE.
- Slice controls: ADD op=sum, no invert, cin 1st bit 0; SUB op=sum, invertB, cin 1; SLT computes A−B as SUB; XOR/AND/OR select logic output, no invert, carry ignored.
- On MSB cycle capture carry-in and carry-out of slice: overflow = cin_msb ^ cout_msb; carryout = cout_msb (ADD/SUB only).
- SLT: result = {WIDTH-1 zeros, sum_msb ^ overflow}; carryout=overflow=0.
- Reserved commands: run full latency, result=0, flags 0, zero=1.
- DONE: result/flags/zero update, done=1 for one cycle, → IDLE.
- start during RUN/DONE ignored (no queueing).
- Async reset mid-operation: immediate return to IDLE with reset values; in-flight op discarded.

## Timing
- Acceptance edge E0 (start=1, ready=1). Edges E1..EWIDTH process bits 0..WIDTH-1; DONE entered after EWIDTH; done high during cycle following EWIDTH; outputs valid from that cycle.
- Latency: done asserts WIDTH+1 cycles after the cycle start was asserted; ready low for WIDTH+1 cycles.
- Back-to-back: start may be asserted in the cycle after done (ready=1); throughput one op per WIDTH+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ALU_ABORT_EN defined: adds input abort (1 bit). abort=1 in RUN → next edge IDLE, no done pulse, result/flags unchanged. abort ignored in IDLE/DONE.
- Undefined: no abort port; every accepted op completes.

## Structure
- Package serial_alu_pkg: command code constants, state enum (IDLE/RUN/DONE), slice operation select constants (sum, xor, less, and, or), control struct {op, invertA, invertB, cin0}.
- Sub-module serial_alu_slice: combinational 1-bit slice (invert muxes, full adder, logic ops, output select); controller owns all flops.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, carryout 1, overflow 0, zero 1; done exactly WIDTH+1 cycles after start.
- SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF, carryout 1, overflow 1, zero 0.
- SLT 0xFFFFFFFF vs 0x00000001 → 0x00000001; SLT 0x7FFFFFFF vs 0x80000000 → 0x00000000 (overflow-corrected).
- XOR/AND/OR of 0xF0F0F0F0, 0xFF00FF00 → 0x0FF00FF0 / 0xF000F000 / 0xFFF0FFF0, carryout=overflow=0.
- start pulsed mid-RUN with different operands → ignored, first result intact; back-to-back start in cycle after done accepted.
- reset asserted at bit 10 of ADD → outputs return to reset values immediately, ready=1, no done; with SERIAL_ALU_ABORT_EN, abort at bit 5 → IDLE next edge, previous result retained.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared command codes, FSM state type, slice operation
// selects and the per-bit slice control word for the bit-serial ALU.
package serial_alu_pkg;

    // Command encodings presented on the command input
    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_XOR = 3'd2;
    localparam logic [2:0] CMD_SLT = 3'd3;
    localparam logic [2:0] CMD_AND = 3'd4;
    localparam logic [2:0] CMD_OR  = 3'd5;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice output select
    localparam logic [2:0] OP_SUM  = 3'd0;
    localparam logic [2:0] OP_XOR  = 3'd1;
    localparam logic [2:0] OP_LESS = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;

    // Per-operation slice controls; cin0 is the carry into bit 0
    typedef struct packed {
        logic [2:0] op;
        logic       invert_a;
        logic       invert_b;
        logic       cin0;
    } slice_ctrl_t;

    // Map a command onto slice controls. SLT runs as a subtraction and is
    // resolved from the sign/overflow of A-B once the MSB has been processed.
    function automatic slice_ctrl_t decode_cmd(input logic [2:0] cmd);
        slice_ctrl_t ctrl;
        ctrl.op       = OP_SUM;
        ctrl.invert_a = 1'b0;
        ctrl.invert_b = 1'b0;
        ctrl.cin0     = 1'b0;
        case (cmd)
            CMD_ADD: begin
                ctrl.op = OP_SUM;
            end
            CMD_SUB, CMD_SLT: begin
                ctrl.op       = OP_SUM;
                ctrl.invert_b = 1'b1;
                ctrl.cin0     = 1'b1;
            end
            CMD_XOR: begin
                ctrl.op = OP_XOR;
            end
            CMD_AND: begin
                ctrl.op = OP_AND;
            end
            CMD_OR: begin
                ctrl.op = OP_OR;
            end
            default: begin
                ctrl.op = OP_SUM;
            end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// serial_alu_slice: purely combinational 1-bit ALU slice (operand invert
// muxes, full adder, bitwise logic and output select). No state here; the
// controller owns the carry flop and all shift registers.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic [2:0] op_i,
    input  logic       invert_a_i,
    input  logic       invert_b_i,
    output logic       res_o,
    output logic       cout_o
);

    logic a_s;
    logic b_s;
    logic sum_s;

    // Optional operand inversion followed by the full adder
    always_comb begin
        a_s    = invert_a_i ? ~a_i : a_i;
        b_s    = invert_b_i ? ~b_i : b_i;
        sum_s  = a_s ^ b_s ^ cin_i;
        cout_o = (a_s & b_s) | (a_s & cin_i) | (b_s & cin_i);
    end

    // Select the slice output bit for the requested operation
    always_comb begin
        res_o = 1'b0;
        case (op_i)
            OP_SUM:  res_o = sum_s;
            OP_XOR:  res_o = a_s ^ b_s;
            OP_LESS: res_o = less_i;
            OP_AND:  res_o = a_s & b_s;
            OP_OR:   res_o = a_s | b_s;
            default: res_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU controller. Accepts a command in IDLE,
// streams operands LSB-first through one serial_alu_slice over WIDTH cycles,
// then publishes result and flags with a one-cycle done pulse.
// Optional feature macro: SERIAL_ALU_ABORT_EN adds an abort input that
// cancels an operation in RUN without touching the published outputs.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SERIAL_ALU_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    slice_ctrl_t      ctrl_s;
    logic             slice_res_s;
    logic             slice_cout_s;
    logic [WIDTH-1:0] word_s;
    logic             ovf_s;
    logic [WIDTH-1:0] fin_res_s;
    logic             fin_co_s;
    logic             fin_ov_s;

    // In IDLE decode the incoming command (carry preload); otherwise the latched one
    always_comb begin
        if (state_q == ST_IDLE) begin
            ctrl_s = decode_cmd(command);
        end else begin
            ctrl_s = decode_cmd(cmd_q);
        end
    end

    serial_alu_slice u_slice (
        .a_i        (a_q[0]),
        .b_i        (b_q[0]),
        .cin_i      (carry_q),
        .less_i     (1'b0),
        .op_i       (ctrl_s.op),
        .invert_a_i (ctrl_s.invert_a),
        .invert_b_i (ctrl_s.invert_b),
        .res_o      (slice_res_s),
        .cout_o     (slice_cout_s)
    );

    // Full result word including the bit produced this cycle; on the MSB
    // cycle carry_q is the carry into the MSB, so this xor is signed overflow.
    assign word_s = {slice_res_s, sr_q[WIDTH-1:1]};
    assign ovf_s  = carry_q ^ slice_cout_s;

    // Final result/flags as seen on the MSB cycle, per command
    always_comb begin
        fin_res_s = word_s;
        fin_co_s  = 1'b0;
        fin_ov_s  = 1'b0;
        case (cmd_q)
            CMD_ADD, CMD_SUB: begin
                fin_res_s = word_s;
                fin_co_s  = slice_cout_s;
                fin_ov_s  = ovf_s;
            end
            CMD_SLT: begin
                fin_res_s = {{(WIDTH-1){1'b0}}, slice_res_s ^ ovf_s};
            end
            CMD_XOR, CMD_AND, CMD_OR: begin
                fin_res_s = word_s;
            end
            default: begin
                fin_res_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sr_d       = sr_q;
        cmd_d      = cmd_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = operandA;
                    b_d     = operandB;
                    cmd_d   = command;
                    sr_d    = {WIDTH{1'b0}};
                    carry_d = ctrl_s.cin0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef SERIAL_ALU_ABORT_EN
                if (abort) begin
                    state_d = ST_IDLE;
                end else
`endif
                begin
                    a_d     = {1'b0, a_q[WIDTH-1:1]};
                    b_d     = {1'b0, b_q[WIDTH-1:1]};
                    sr_d    = word_s;
                    carry_d = slice_cout_s;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        result_d   = fin_res_s;
                        carryout_d = fin_co_s;
                        overflow_d = fin_ov_s;
                        zero_d     = (fin_res_s == {WIDTH{1'b0}});
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            sr_q       <= {WIDTH{1'b0}};
            cmd_q      <= 3'd0;
            carry_q    <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            result_q   <= {WIDTH{1'b0}};
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sr_q       <= sr_d;
            cmd_q      <= cmd_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule
